// File: rtl/pll_prog_arbiter.sv
// rtl/pll_prog_arbiter.sv - round-robin ADF4360 3-wire programming arbiter with lock-detect filter
module pll_prog_arbiter #(
    parameter int P_CLK_DIV = 8,
    parameter int P_WORD_W  = 24,
    parameter int P_GAP     = 4,
    parameter int P_LD_FILT = 16
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_req0,
    input  logic [P_WORD_W-1:0] in_data0,
    output logic                out_ack0,
    input  logic                in_req1,
    input  logic [P_WORD_W-1:0] in_data1,
    output logic                out_ack1,
    output logic                out_busy,
    output logic                out_clk,
    output logic                out_data,
    output logic                out_le,
    input  logic                in_ld,
    input  logic                in_clr_lost,
    output logic                out_locked,
    output logic                out_lock_lost
);
    localparam int DIV_W = $clog2(P_CLK_DIV);
    localparam int BIT_W = $clog2(P_WORD_W);
    localparam int GAP_W = $clog2(P_GAP + 1);
    localparam int LD_W  = $clog2(P_LD_FILT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(P_CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(P_WORD_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(P_GAP - 1);
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(P_LD_FILT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [P_WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                ld_s1_q, ld_s1_d;
    logic                ld_s2_q, ld_s2_d;
    logic [LD_W-1:0]     ld_cnt_q, ld_cnt_d;
    logic                locked_q, locked_d;
    logic                lost_q, lost_d;

    logic div_last;
    logic grant0;
    logic grant1;
    logic ld_flip;

    assign div_last = (div_cnt_q == DIV_LAST);
    // last_grant_q==1 means requester 1 was served last, so requester 0 wins a tie
    assign grant0   = in_req0 && (!in_req1 || last_grant_q);
    assign grant1   = in_req1 && !grant0;
    assign ld_flip  = (ld_s2_q != locked_q) && (ld_cnt_q == LD_LAST);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            ld_s1_q      <= 1'b0;
            ld_s2_q      <= 1'b0;
            ld_cnt_q     <= '0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            ld_s1_q      <= ld_s1_d;
            ld_s2_q      <= ld_s2_d;
            ld_cnt_q     <= ld_cnt_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = ST_SHIFT;
                    shreg_d      = grant0 ? in_data0 : in_data1;
                    last_grant_d = grant1;
                    bit_cnt_d    = BIT_LAST;
                    div_cnt_d    = '0;
                    ack0_d       = grant0;
                    ack1_d       = grant1;
                end
            end
            ST_SHIFT: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        shreg_d   = {shreg_q[P_WORD_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
        endcase

        // Lock filter: run of samples disagreeing with the current flag
        ld_s1_d  = in_ld;
        ld_s2_d  = ld_s1_q;
        locked_d = locked_q;
        ld_cnt_d = '0;
        if (ld_flip) begin
            locked_d = !locked_q;
        end else if (ld_s2_q != locked_q) begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
        end

        lost_d = lost_q;
        if (ld_flip && locked_q) begin
            lost_d = 1'b1;
        end else if (in_clr_lost) begin
            lost_d = 1'b0;
        end
    end

    always_comb begin
        out_busy = (state_q != ST_IDLE);
        out_clk  = 1'b0;
        out_data = 1'b0;
        out_le   = 1'b0;
        if (state_q == ST_SHIFT) begin
            out_clk  = (div_cnt_q >= DIV_HALF);
            out_data = shreg_q[P_WORD_W-1];
        end else if (state_q == ST_LATCH) begin
            out_le = 1'b1;
        end
    end

    assign out_ack0      = ack0_q;
    assign out_ack1      = ack1_q;
    assign out_locked    = locked_q;
    assign out_lock_lost = lost_q;

endmodule
